flash_burst_reader: RTL and testbench
=====================================

// Module: flash_burst_reader
// PURPOSE
// - Parametrised successor to the single-word flash memory controller.
// - Accepts a burst read request (start address, beat count) over a valid/ready handshake.
// - Drives active-low CE/OE/WE to a parallel NOR flash with programmable setup/access wait states.
// - Returns each word on a valid/ready response stream with backpressure; sits between the
//   weight/image loader and the external flash.
// PARAMETERS
// - ADDR_W     16  flash address width
// - DATA_W     16  flash data width
// - LEN_W       4  burst length field width; beats = req_len+1 (1..2^LEN_W)
// - CE_SETUP    5  cycles CE low before OE asserts (>=1)
// - OE_ACCESS   5  cycles OE low before data is sampled (>=1)
// - PAGE_W      2  page offset bits (page-mode only)
// - PAGE_ACCESS 2  intra-page access cycles (page-mode only, >=1)
// PORTS
// - clk         in   1       system clock, rising edge
// - n_rst       in   1       asynchronous active-low reset
// - req_valid   in   1       burst request valid
// - req_ready   out  1       high only in IDLE
// - req_addr    in   ADDR_W  first word address
// - req_len     in   LEN_W   beats minus one
// - rsp_valid   out  1       rsp_data holds a word
// - rsp_ready   in   1       consumer accepts word
// - rsp_data    out  DATA_W  registered read data
// - rsp_last    out  1       qualifies final beat of burst
// - busy        out  1       state != IDLE
// - flash_addr  out  ADDR_W  registered flash address
// - flash_data  in   DATA_W  flash data bus
// - flash_ce_n  out  1       chip enable, active low
// - flash_oe_n  out  1       output enable, active low
// - flash_we_n  out  1       write enable, tied 1 (read-only)
// BEHAVIOUR
// - Reset values: flash_ce_n=1, flash_oe_n=1, flash_we_n=1, flash_addr=0, rsp_data=0,
//   rsp_valid=0, rsp_last=0, busy=0, req_ready=1. State IDLE; beat and wait counters = 0.
// - Reset mid-burst aborts immediately; there is no resume.
// - FSM states: IDLE -> SETUP -> ACCESS -> RESP -> (SETUP | IDLE).
// - IDLE:
//   - On req_valid&&req_ready at edge T: latch req_addr into flash_addr, latch req_len
//     into beat counter, go SETUP.
//   - req_valid with req_ready=0 is ignored (held off by the requester).
// - SETUP:
//   - ce_n=0, oe_n=1.
//   - Lasts exactly CE_SETUP cycles, then ACCESS.
// - ACCESS:
//   - ce_n=0, oe_n=0.
//   - Lasts exactly OE_ACCESS cycles.
//   - flash_data is captured into rsp_data on the edge ending the final ACCESS cycle;
//     go RESP.
// - RESP:
//   - rsp_valid=1; ce_n=1, oe_n=1.
//   - rsp_last=1 when beat counter==0.
//   - rsp_data, rsp_last and flash_addr are held stable while rsp_ready=0 (unbounded stall).
//   - On rsp_valid&&rsp_ready with last beat: go IDLE.
//   - On rsp_valid&&rsp_ready otherwise: flash_addr+=1 (wraps modulo 2^ADDR_W,
//     0xFFFF->0x0000), beat counter-=1, go SETUP.
// - Latency: first rsp_valid is high in cycle T+CE_SETUP+OE_ACCESS+1
//   (defaults: 11 cycles after acceptance).
// - Back-to-back beats with rsp_ready=1: one word per CE_SETUP+OE_ACCESS+1 cycles.
// - A new request is accepted no earlier than the cycle after the last beat handshake
//   (req_ready rises in that cycle).
// - Wait counter width is $clog2(max(CE_SETUP,OE_ACCESS,PAGE_ACCESS)+1). The counter
//   clears on every state entry.
// CONFIGURATION
// - Macro FLASH_BURST_PAGE_MODE_EN, undefined by default.
// - Undefined: behaviour exactly as above. PAGE_W and PAGE_ACCESS are unused.
// - Defined:
//   - In RESP, flash_ce_n stays 0 and flash_oe_n stays 0; the RESP exit test is unchanged.
//   - On a non-last handshake, if the incremented flash_addr[PAGE_W-1:0]!=0, go directly
//     to ACCESS lasting PAGE_ACCESS cycles (no SETUP).
//   - If the incremented address crosses a page boundary, take the normal
//     SETUP/OE_ACCESS path.
//   - flash_ce_n and flash_oe_n return to 1 in IDLE.
// TESTING
// - Reset, no requests -> ce_n=oe_n=we_n=1, req_ready=1, rsp_valid=0 for 20 cycles.
// - Single read: addr=0x0040, len=0, flash_data=0xBEEF, rsp_ready=1
//   -> ce_n low 10 cycles, oe_n low last 5 of those;
//      rsp_valid=1 with rsp_data=0xBEEF, rsp_last=1 at T+11; IDLE at T+12.
// - Burst len=3 from 0x0100, flash_data=address ^ 0xA5A5
//   -> 4 beats 0xA4A5,0xA4A4,0xA4A7,0xA4A6; rsp_last only on 4th beat;
//      beat spacing 11 cycles.
// - Backpressure: hold rsp_ready=0 for 7 cycles on beat 2 -> rsp_data/flash_addr stable,
//   ce_n=oe_n=1; resumes correctly after release.
// - Wrap: addr=0xFFFF, len=1 -> flash_addr 0xFFFF then 0x0000.
// - Reset mid-ACCESS (n_rst low 2 cycles) -> outputs return to reset values asynchronously;
//   new request afterwards completes normally.
// - Page mode (PAGE_W=2): addr=0x0001, len=3 -> beats 2-3 use 2-cycle ACCESS with no SETUP;
//   beat 4 (0x0004) uses full SETUP+ACCESS.

Source files
------------

// File: rtl/flash_burst_reader_if.sv
// Request, response and flash-bus signals of flash_burst_reader.
// master: requester/consumer/flash side; slave: the burst controller.
interface flash_burst_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              busy;
    logic [ADDR_W-1:0] flash_addr;
    logic [DATA_W-1:0] flash_data;
    logic              flash_ce_n;
    logic              flash_oe_n;
    logic              flash_we_n;

    modport master (
        output req_valid, req_addr, req_len, rsp_ready, flash_data,
        input  req_ready, rsp_valid, rsp_data, rsp_last, busy,
               flash_addr, flash_ce_n, flash_oe_n, flash_we_n
    );

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready, flash_data,
        output req_ready, rsp_valid, rsp_data, rsp_last, busy,
               flash_addr, flash_ce_n, flash_oe_n, flash_we_n
    );
endinterface

// File: rtl/flash_burst_reader.sv
// Burst read controller for a parallel NOR flash: valid/ready request in, one word per beat out.
// Define FLASH_BURST_PAGE_MODE_EN to keep CE/OE low across beats and use short intra-page accesses.
module flash_burst_reader #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int LEN_W       = 4,
    parameter int CE_SETUP    = 5,
    parameter int OE_ACCESS   = 5,
    parameter int PAGE_W      = 2,
    parameter int PAGE_ACCESS = 2
) (
    input logic                 clk,
    input logic                 n_rst,
    flash_burst_reader_if.slave bus
);
    localparam int MAX_WAIT = (CE_SETUP > OE_ACCESS)
        ? ((CE_SETUP > PAGE_ACCESS) ? CE_SETUP : PAGE_ACCESS)
        : ((OE_ACCESS > PAGE_ACCESS) ? OE_ACCESS : PAGE_ACCESS);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] SETUP_LAST  = WAIT_W'(CE_SETUP - 1);
    localparam logic [WAIT_W-1:0] ACCESS_LAST = WAIT_W'(OE_ACCESS - 1);

    if (CE_SETUP < 1 || OE_ACCESS < 1 || PAGE_ACCESS < 1 || PAGE_W < 1 || PAGE_W >= ADDR_W) begin : gBadParams
        $error("flash_burst_reader: wait states must be >= 1 and PAGE_W within the address");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [WAIT_W-1:0] accessLast;
    logic [LEN_W-1:0]  beatCnt_q, beatCnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addrInc;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ceN, oeN;
`ifdef FLASH_BURST_PAGE_MODE_EN
    localparam logic [WAIT_W-1:0] PAGE_LAST = WAIT_W'(PAGE_ACCESS - 1);
    logic pageHit_q, pageHit_d;
`endif

    assign addrInc = addr_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            beatCnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef FLASH_BURST_PAGE_MODE_EN
            pageHit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            beatCnt_q <= beatCnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef FLASH_BURST_PAGE_MODE_EN
            pageHit_q <= pageHit_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
`ifdef FLASH_BURST_PAGE_MODE_EN
        pageHit_d  = pageHit_q;
        accessLast = pageHit_q ? PAGE_LAST : ACCESS_LAST;
`else
        accessLast = ACCESS_LAST;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d    = bus.req_addr;
                    beatCnt_d = bus.req_len;
                    state_d   = SETUP;
`ifdef FLASH_BURST_PAGE_MODE_EN
                    pageHit_d = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (waitCnt_q == SETUP_LAST) state_d = ACCESS;
            end
            ACCESS: begin
                if (waitCnt_q == accessLast) begin
                    data_d  = bus.flash_data;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (beatCnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        addr_d    = addrInc;
                        beatCnt_d = beatCnt_q - LEN_W'(1);
`ifdef FLASH_BURST_PAGE_MODE_EN
                        // Staying inside the open page skips CE setup entirely.
                        pageHit_d = (addrInc[PAGE_W-1:0] != '0);
                        state_d   = pageHit_d ? ACCESS : SETUP;
`else
                        state_d   = SETUP;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            waitCnt_d = '0;
        end else if (state_q == SETUP || state_q == ACCESS) begin
            waitCnt_d = waitCnt_q + WAIT_W'(1);
        end else begin
            waitCnt_d = waitCnt_q;
        end
    end

    always_comb begin
        ceN = 1'b1;
        oeN = 1'b1;
        case (state_q)
            SETUP: ceN = 1'b0;
            ACCESS: begin
                ceN = 1'b0;
                oeN = 1'b0;
            end
`ifdef FLASH_BURST_PAGE_MODE_EN
            RESP: begin
                ceN = 1'b0;
                oeN = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_last   = (state_q == RESP) && (beatCnt_q == '0);
    assign bus.rsp_data   = data_q;
    assign bus.flash_addr = addr_q;
    assign bus.flash_ce_n = ceN;
    assign bus.flash_oe_n = oeN;
    assign bus.flash_we_n = 1'b1;
endmodule

// File: tb/tb_flash_burst_reader.sv
// Self-checking bench for flash_burst_reader: table of burst requests with a response scoreboard,
// plus hand-written reset-idle and reset-mid-burst sequences.
module tb_flash_burst_reader;
    localparam int CE_SETUP    = 5;
    localparam int OE_ACCESS   = 5;
    localparam int PAGE_W      = 2;
    localparam int PAGE_ACCESS = 2;
    localparam int FULL_BEAT   = CE_SETUP + OE_ACCESS + 1;
    localparam int TIMEOUT     = 1000;
`ifdef FLASH_BURST_PAGE_MODE_EN
    localparam logic STALL_CTRL = 1'b0;
`else
    localparam logic STALL_CTRL = 1'b1;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  len;
        logic [15:0] key;
        int          stallBeat;
        int          stallCycles;
        logic [15:0] expFirstData;
        logic [15:0] expLastData;
        int          expLatency;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        logic        last;
    } beat_t;

    logic        clk;
    logic        n_rst;
    logic [15:0] flashKey;
    beat_t       sbQ[$];
    vec_t        vecs[5];
    int          checkCount;
    int          passCount;

    flash_burst_reader_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(4)) bus();

    flash_burst_reader #(
        .ADDR_W(16), .DATA_W(16), .LEN_W(4),
        .CE_SETUP(CE_SETUP), .OE_ACCESS(OE_ACCESS),
        .PAGE_W(PAGE_W), .PAGE_ACCESS(PAGE_ACCESS)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    // Flash model: each word reads back as its address XOR a per-test key.
    assign bus.flash_data = bus.flash_addr ^ flashKey;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int expSpacing(input logic [15:0] beatAddr);
`ifdef FLASH_BURST_PAGE_MODE_EN
        if (beatAddr[PAGE_W-1:0] != '0) return PAGE_ACCESS + 1;
`else
        if (beatAddr == 16'hFFFF) return FULL_BEAT;
`endif
        return FULL_BEAT;
    endfunction

    // Called at a falling edge; drives the request and pushes the beats it should produce.
    task automatic applyStimulus(input vec_t v);
        int    waitCycles;
        beat_t b;
        waitCycles = 0;
        while (!bus.req_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!bus.req_ready) checkOutput("reqReadyWait", {31'd0, bus.req_ready}, 32'd1);
        flashKey      = v.key;
        bus.req_addr  = v.addr;
        bus.req_len   = v.len;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i <= int'(v.len); i++) begin
            b.addr = v.addr + 16'(i);
            b.data = b.addr ^ v.key;
            b.last = (i == int'(v.len));
            sbQ.push_back(b);
        end
    endtask

    task automatic runVector(input vec_t v);
        int          cycle, beatIdx, lastAppear, stallLeft, ceLow, oeLow, spacing;
        logic        prevValid, stallOk;
        logic [15:0] heldData, heldAddr;
        beat_t       exp;
        applyStimulus(v);
        cycle = 0; beatIdx = 0; lastAppear = 0; stallLeft = 0; ceLow = 0; oeLow = 0;
        prevValid = 1'b0; stallOk = 1'b1; heldData = '0; heldAddr = '0;
        while (sbQ.size() != 0 && cycle < TIMEOUT) begin
            @(negedge clk);
            cycle++;
            if (cycle == 1) begin
                bus.req_valid = 1'b0;
                checkOutput("accepted", {31'd0, bus.busy}, 32'd1);
            end
            if (!bus.flash_ce_n) ceLow++;
            if (!bus.flash_oe_n) oeLow++;
            if (stallLeft > 0) begin
                if (bus.rsp_data !== heldData || bus.flash_addr !== heldAddr || bus.rsp_valid !== 1'b1 ||
                    bus.flash_ce_n !== STALL_CTRL || bus.flash_oe_n !== STALL_CTRL) stallOk = 1'b0;
                stallLeft--;
                if (stallLeft == 0) begin
                    bus.rsp_ready = 1'b1;
                    checkOutput("stallStable", {31'd0, stallOk}, 32'd1);
                end
            end
            if (bus.rsp_valid && !prevValid) begin
                if (beatIdx == 0) begin
                    checkOutput("firstLatency", cycle, v.expLatency);
                end else begin
                    spacing = expSpacing(v.addr + 16'(beatIdx));
                    if (beatIdx - 1 == v.stallBeat) spacing += v.stallCycles;
                    checkOutput("beatSpacing", cycle - lastAppear, spacing);
                end
                lastAppear = cycle;
                if (beatIdx == v.stallBeat && v.stallCycles > 0) begin
                    bus.rsp_ready = 1'b0;
                    stallLeft     = v.stallCycles;
                    heldData      = bus.rsp_data;
                    heldAddr      = bus.flash_addr;
                end
            end
            prevValid = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                exp = sbQ.pop_front();
                checkOutput("beatData", bus.rsp_data, exp.data);
                checkOutput("beatAddr", bus.flash_addr, exp.addr);
                checkOutput("beatLast", {31'd0, bus.rsp_last}, {31'd0, exp.last});
                if (beatIdx == 0) checkOutput("firstData", bus.rsp_data, v.expFirstData);
                if (exp.last) checkOutput("lastData", bus.rsp_data, v.expLastData);
                beatIdx++;
            end
        end
        if (sbQ.size() != 0) begin
            checkOutput("beatTimeout", sbQ.size(), 0);
            sbQ.delete();
        end
        bus.rsp_ready = 1'b1;
`ifndef FLASH_BURST_PAGE_MODE_EN
        checkOutput("ceLowCycles", ceLow, (int'(v.len) + 1) * (CE_SETUP + OE_ACCESS));
        checkOutput("oeLowCycles", oeLow, (int'(v.len) + 1) * OE_ACCESS);
`endif
        @(negedge clk);
        checkOutput("idleAfter", {29'd0, bus.req_ready, bus.busy, bus.rsp_valid}, 32'b100);
        checkOutput("weHigh", {31'd0, bus.flash_we_n}, 32'd1);
    endtask

    initial begin
        vec_t postVec;
        vec_t abortVec;
        vec_t pageVec;
        logic idleOk;
        checkCount = 0;
        passCount  = 0;
        flashKey   = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b1;

        //          addr      len  key       stallBeat stall firstData lastData  latency
        vecs[0] = '{16'h0040, 4'd0,  16'hBEAF, -1, 0, 16'hBEEF, 16'hBEEF, FULL_BEAT};
        vecs[1] = '{16'h0100, 4'd3,  16'hA5A5, -1, 0, 16'hA4A5, 16'hA4A6, FULL_BEAT};
        vecs[2] = '{16'h0200, 4'd2,  16'h1234,  1, 7, 16'h1034, 16'h1036, FULL_BEAT};
        vecs[3] = '{16'hFFFF, 4'd1,  16'h0F0F, -1, 0, 16'hF0F0, 16'h0F0F, FULL_BEAT};
        vecs[4] = '{16'h7FFE, 4'd15, 16'h0000, -1, 0, 16'h7FFE, 16'h800D, FULL_BEAT};

        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetRegs", {bus.flash_addr, bus.rsp_data}, 32'd0);
        checkOutput("resetCtrl",
                    {25'd0, bus.flash_ce_n, bus.flash_oe_n, bus.flash_we_n, bus.req_ready,
                     bus.rsp_valid, bus.rsp_last, bus.busy}, 32'b1111000);
        n_rst = 1'b1;

        idleOk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.flash_ce_n !== 1'b1 || bus.flash_oe_n !== 1'b1 || bus.flash_we_n !== 1'b1 ||
                bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) idleOk = 1'b0;
        end
        checkOutput("resetIdle20", {31'd0, idleOk}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d: addr=0x%04h len=%0d", i, vecs[i].addr, vecs[i].len);
            runVector(vecs[i]);
        end

        // Abort a burst from inside ACCESS with an asynchronous reset.
        abortVec = '{16'h0300, 4'd2, 16'h5555, -1, 0, 16'h5655, 16'h5657, FULL_BEAT};
        applyStimulus(abortVec);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("inAccess", {30'd0, bus.flash_ce_n, bus.flash_oe_n}, 32'b00);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("abortRegs", {bus.flash_addr, bus.rsp_data}, 32'd0);
        checkOutput("abortCtrl",
                    {25'd0, bus.flash_ce_n, bus.flash_oe_n, bus.flash_we_n, bus.req_ready,
                     bus.rsp_valid, bus.rsp_last, bus.busy}, 32'b1111000);
        sbQ.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        postVec = '{16'h0ABC, 4'd1, 16'h3C3C, -1, 0, 16'h3680, 16'h3681, FULL_BEAT};
        runVector(postVec);

        // Crosses a 4-word page boundary at 0x0004; intra-page beats are short in page mode.
        pageVec = '{16'h0001, 4'd3, 16'h0000, -1, 0, 16'h0001, 16'h0004, FULL_BEAT};
        runVector(pageVec);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
